// File: rtl/byte_sram_arbiter.sv
// Two-port arbiter onto one registered single-port byte SRAM; one access per clock.
// Issue at the accept edge, read data returns 2 clocks later; requesters wait on combinational ack.
module byte_sram_arbiter #(
  parameter int ADDRWIDTH = 16
) (
  input  logic                 in_clock,
  input  logic                 in_reset_n,
  input  logic                 in_a_req,
  input  logic                 in_a_we,
  input  logic [ADDRWIDTH-1:0] in_a_addr,
  input  logic [7:0]           in_a_wdata,
  output logic                 out_a_ack,
  output logic [7:0]           out_a_rdata,
  output logic                 out_a_rvalid,
  input  logic                 in_b_req,
  input  logic                 in_b_we,
  input  logic [ADDRWIDTH-1:0] in_b_addr,
  input  logic [7:0]           in_b_wdata,
  input  logic                 in_b_urgent,
  output logic                 out_b_ack,
  output logic [7:0]           out_b_rdata,
  output logic                 out_b_rvalid,
  output logic                 out_mem_writeenable,
  output logic [ADDRWIDTH-1:0] out_mem_addr,
  output logic [7:0]           out_mem_data,
  input  logic [7:0]           in_mem_data
);

  logic last_grant_b;
  logic grant_a;
  logic grant_b;
  // Tag pipeline: stage 0 covers the SRAM sample edge, stage 1 the return edge.
  logic tag0_vld;
  logic tag0_b;
  logic tag1_vld;
  logic tag1_b;

  // Acks are gated by reset so nothing is consumed while the block is held.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (in_reset_n) begin
      if (in_a_req && in_b_req) begin
        if (in_b_urgent || !last_grant_b) grant_b = 1'b1;
        else                              grant_a = 1'b1;
      end else begin
        grant_a = in_a_req;
        grant_b = in_b_req;
      end
    end
  end

  assign out_a_ack = grant_a;
  assign out_b_ack = grant_b;

  always_ff @(posedge in_clock or negedge in_reset_n) begin
    if (!in_reset_n) begin
      last_grant_b <= 1'b1;
    end else if (grant_a) begin
      last_grant_b <= 1'b0;
    end else if (grant_b) begin
      last_grant_b <= 1'b1;
    end
  end

  always_ff @(posedge in_clock or negedge in_reset_n) begin
    if (!in_reset_n) begin
      out_mem_writeenable <= 1'b0;
      out_mem_addr        <= '0;
      out_mem_data        <= '0;
    end else begin
      out_mem_writeenable <= 1'b0;
      if (grant_a) begin
        out_mem_writeenable <= in_a_we;
        out_mem_addr        <= in_a_addr;
        out_mem_data        <= in_a_wdata;
      end else if (grant_b) begin
        out_mem_writeenable <= in_b_we;
        out_mem_addr        <= in_b_addr;
        out_mem_data        <= in_b_wdata;
      end
    end
  end

  always_ff @(posedge in_clock or negedge in_reset_n) begin
    if (!in_reset_n) begin
      tag0_vld <= 1'b0;
      tag0_b   <= 1'b0;
      tag1_vld <= 1'b0;
      tag1_b   <= 1'b0;
    end else begin
      tag0_vld <= (grant_a && !in_a_we) || (grant_b && !in_b_we);
      tag0_b   <= grant_b;
      tag1_vld <= tag0_vld;
      tag1_b   <= tag0_b;
    end
  end

  always_ff @(posedge in_clock or negedge in_reset_n) begin
    if (!in_reset_n) begin
      out_a_rdata  <= '0;
      out_b_rdata  <= '0;
      out_a_rvalid <= 1'b0;
      out_b_rvalid <= 1'b0;
    end else begin
      out_a_rvalid <= tag1_vld && !tag1_b;
      out_b_rvalid <= tag1_vld && tag1_b;
      if (tag1_vld && !tag1_b) out_a_rdata <= in_mem_data;
      if (tag1_vld && tag1_b)  out_b_rdata <= in_mem_data;
    end
  end

endmodule

// File: tb/tb_byte_sram_arbiter.sv
// Directed bench for byte_sram_arbiter with a write-first registered SRAM model attached.
module tb_byte_sram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0, b_urgent = 1'b0;
  logic [15:0] a_addr = '0, b_addr = '0;
  logic [7:0]  a_wdata = '0, b_wdata = '0;
  logic        a_ack, a_rvalid, b_ack, b_rvalid, mem_we;
  logic [7:0]  a_rdata, b_rdata, mem_wdata, mem_rdata;
  logic [15:0] mem_addr;
  logic [7:0]  sram [0:65535];
  int          n_chk = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  byte_sram_arbiter #(.ADDRWIDTH(16)) dut (
    .in_clock(clk), .in_reset_n(rst_n),
    .in_a_req(a_req), .in_a_we(a_we), .in_a_addr(a_addr), .in_a_wdata(a_wdata),
    .out_a_ack(a_ack), .out_a_rdata(a_rdata), .out_a_rvalid(a_rvalid),
    .in_b_req(b_req), .in_b_we(b_we), .in_b_addr(b_addr), .in_b_wdata(b_wdata),
    .in_b_urgent(b_urgent),
    .out_b_ack(b_ack), .out_b_rdata(b_rdata), .out_b_rvalid(b_rvalid),
    .out_mem_writeenable(mem_we), .out_mem_addr(mem_addr), .out_mem_data(mem_wdata),
    .in_mem_data(mem_rdata)
  );

  always @(posedge clk) begin
    if (mem_we) sram[mem_addr] <= mem_wdata;
    mem_rdata <= mem_we ? mem_wdata : sram[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_req = 1'b0; a_we = 1'b0; b_req = 1'b0; b_we = 1'b0; b_urgent = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      sram[16'h0200 + 16'(i)] = 8'h10 + 8'(i);
      sram[16'h0300 + 16'(i)] = 8'h80 + 8'(i);
    end
    sram[16'h0ABC] = 8'h6C;
    #2;
    // 1: reset state, then B write / A read of the same byte
    rst_n = 1'b0;
    a_req = 1'b1; b_req = 1'b1;
    @(negedge clk);
    chk("rst_a_ack", 32'(a_ack), 32'd0);
    chk("rst_b_ack", 32'(b_ack), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_data", 32'(mem_wdata), 32'd0);
    chk("rst_rvalid", 32'({a_rvalid, b_rvalid}), 32'd0);
    chk("rst_rdata", 32'({a_rdata, b_rdata}), 32'd0);
    cyc();
    idle_inputs();
    rst_n = 1'b1;
    cyc();
    b_req = 1'b1; b_we = 1'b1; b_addr = 16'h0010; b_wdata = 8'h5A;
    @(negedge clk);
    chk("t1_b_ack", 32'(b_ack), 32'd1);
    chk("t1_a_ack0", 32'(a_ack), 32'd0);
    cyc();
    b_req = 1'b0;
    a_req = 1'b1; a_we = 1'b0; a_addr = 16'h0010;
    @(negedge clk);
    chk("t1_a_ack", 32'(a_ack), 32'd1);
    chk("t1_issue_we", 32'(mem_we), 32'd1);
    chk("t1_issue_addr", 32'(mem_addr), 32'h0010);
    chk("t1_issue_data", 32'(mem_wdata), 32'h5A);
    cyc();
    a_req = 1'b0;
    @(negedge clk);
    chk("t1_rv_early1", 32'(a_rvalid), 32'd0);
    chk("t1_rd_we", 32'(mem_we), 32'd0);
    cyc();
    @(negedge clk);
    chk("t1_rv_early2", 32'(a_rvalid), 32'd0);
    cyc();
    @(negedge clk);
    chk("t1_a_rvalid", 32'(a_rvalid), 32'd1);
    chk("t1_a_rdata", 32'(a_rdata), 32'h5A);
    chk("t1_b_rvalid", 32'(b_rvalid), 32'd0);
    cyc();
    @(negedge clk);
    chk("t1_rv_pulse", 32'(a_rvalid), 32'd0);

    // 2: both read for 6 cycles, round-robin from A after reset
    do_reset();
    begin
      int na = 0, nb = 0;
      logic ga, gb;
      logic [7:0] exp_d;
      for (int k = 0; k < 9; k++) begin
        a_req = (k < 6); b_req = (k < 6); a_we = 1'b0; b_we = 1'b0;
        a_addr = 16'h0200 + 16'(na); b_addr = 16'h0300 + 16'(nb);
        @(negedge clk);
        ga = a_ack; gb = b_ack;
        if (k < 6) begin
          chk($sformatf("t2_a_ack%0d", k), 32'(a_ack), 32'((k % 2) == 0));
          chk($sformatf("t2_b_ack%0d", k), 32'(b_ack), 32'((k % 2) == 1));
        end
        if (k >= 3) begin
          exp_d = ((k - 3) % 2 == 0) ? 8'h10 + 8'((k - 3) / 2) : 8'h80 + 8'((k - 3) / 2);
          chk($sformatf("t2_a_rv%0d", k), 32'(a_rvalid), 32'((k - 3) % 2 == 0));
          chk($sformatf("t2_b_rv%0d", k), 32'(b_rvalid), 32'((k - 3) % 2 == 1));
          chk($sformatf("t2_rd%0d", k), 32'(((k - 3) % 2 == 0) ? a_rdata : b_rdata), 32'(exp_d));
        end
        cyc();
        if (ga) na++;
        if (gb) nb++;
      end
    end

    // 3: urgent B wins three conflicts, then round-robin resumes with A
    for (int k = 0; k < 6; k++) begin
      a_req = 1'b1; b_req = 1'b1; a_we = 1'b0; b_we = 1'b0;
      b_urgent = (k < 3);
      @(negedge clk);
      chk($sformatf("t3_a_ack%0d", k), 32'(a_ack), 32'(k == 3 || k == 5));
      chk($sformatf("t3_b_ack%0d", k), 32'(b_ack), 32'(k < 3 || k == 4));
      cyc();
    end
    idle_inputs();
    repeat (4) cyc();

    // 4: back-to-back write then read of the same address
    a_req = 1'b1; a_we = 1'b1; a_addr = 16'h0100; a_wdata = 8'h33;
    @(negedge clk);
    chk("t4_ack_wr", 32'(a_ack), 32'd1);
    cyc();
    a_we = 1'b0;
    @(negedge clk);
    chk("t4_ack_rd", 32'(a_ack), 32'd1);
    chk("t4_we_first", 32'(mem_we), 32'd1);
    chk("t4_addr", 32'(mem_addr), 32'h0100);
    cyc();
    a_req = 1'b0;
    @(negedge clk);
    chk("t4_we_second", 32'(mem_we), 32'd0);
    cyc();
    @(negedge clk);
    chk("t4_no_wr_rvalid", 32'(a_rvalid), 32'd0);
    cyc();
    @(negedge clk);
    chk("t4_rvalid", 32'(a_rvalid), 32'd1);
    chk("t4_rdata", 32'(a_rdata), 32'h33);
    cyc();

    // 5: reset pulse with two reads in flight; last grant was A, so reset must restore A priority
    a_req = 1'b1; a_we = 1'b0; a_addr = 16'h0200;
    cyc();
    a_req = 1'b0;
    b_req = 1'b1; b_we = 1'b0; b_addr = 16'h0300;
    cyc();
    rst_n = 1'b0;
    a_req = 1'b1; b_req = 1'b1;
    @(negedge clk);
    chk("t5_acks", 32'({a_ack, b_ack}), 32'd0);
    chk("t5_mem", 32'({mem_we, mem_addr, mem_wdata}), 32'd0);
    chk("t5_rvalid", 32'({a_rvalid, b_rvalid}), 32'd0);
    chk("t5_rdata", 32'({a_rdata, b_rdata}), 32'd0);
    cyc();
    rst_n = 1'b1;
    idle_inputs();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("t5_post_rv%0d", k), 32'({a_rvalid, b_rvalid}), 32'd0);
      cyc();
    end
    a_req = 1'b1; b_req = 1'b1; a_we = 1'b0; b_we = 1'b0; a_addr = 16'h0ABC;
    @(negedge clk);
    chk("t5_conflict_a", 32'(a_ack), 32'd1);
    chk("t5_conflict_b", 32'(b_ack), 32'd0);
    cyc();
    idle_inputs();
    repeat (2) cyc();
    @(negedge clk);
    chk("t5_read_rdata", 32'({a_rvalid, a_rdata}), 32'h16C);
    cyc();

    // 6: ten idle cycles, address holds the last issued value
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("t6_we%0d", k), 32'(mem_we), 32'd0);
      chk($sformatf("t6_addr%0d", k), 32'(mem_addr), 32'h0ABC);
      chk($sformatf("t6_act%0d", k), 32'({a_ack, b_ack, a_rvalid, b_rvalid}), 32'd0);
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/byte_sram_arbiter.md
Name: byte_sram_arbiter

Overview:
- Shares one single-port byte SRAM (registered read, write-first, 1-clock read latency) between two requesters: port A (CPU) and port B (video/DMA fetch).
- Accepts at most one access per clock and drives the SRAM address, data and write enable from registers.
- Routes read data back to the issuing port with a fixed latency.
- Sits between the CPU/video bus logic and the shared SRAM instance.

Parameters:
ADDRWIDTH, 16, SRAM address width; must match the attached SRAM.

Ports:
in_clock  input  1  system clock; all logic on rising edge
in_reset_n  input  1  asynchronous, active-low reset
in_a_req  input  1  port A request; held until accepted
in_a_we  input  1  port A write (1) / read (0)
in_a_addr  input  ADDRWIDTH  port A address
in_a_wdata  input  8  port A write data
out_a_ack  output  1  combinational; request accepted at this clock edge
out_a_rdata  output  8  port A read data
out_a_rvalid  output  1  one-cycle pulse; out_a_rdata valid
in_b_req, in_b_we, in_b_addr, in_b_wdata  input  1/1/ADDRWIDTH/8  port B, same rules as port A
in_b_urgent  input  1  port B wins any conflict while high
out_b_ack, out_b_rdata, out_b_rvalid  output  1/8/1  port B, same rules as port A
out_mem_writeenable  output  1  registered SRAM write enable
out_mem_addr  output  ADDRWIDTH  registered SRAM address
out_mem_data  output  8  registered SRAM write data
in_mem_data  input  8  SRAM registered read data

Behaviour:
- Clock and reset: single clock domain. Reset is asynchronous assert; release is synchronised by the caller.
- Arbitration (combinational, every cycle):
  - Only one requester: it is acked.
  - Both requesting and in_b_urgent=1: B is acked.
  - Both requesting and in_b_urgent=0: round-robin. The port not granted most recently wins.
  - last_grant register updates on every ack, urgent grants included.
  - Reset value of last_grant is B, so A wins the first conflict.
- Ack: at most one of out_a_ack/out_b_ack is high. Ack is never high without the matching req. The request is consumed at the rising edge where ack=1. The requester may present a new request in the next cycle (back-to-back, 1 access/clock).
- Issue stage (edge E0, ack high):
  - out_mem_addr, out_mem_data and out_mem_writeenable are loaded from the granted port.
  - With no grant, out_mem_writeenable loads 0. out_mem_addr and out_mem_data hold.
- Read return:
  - Edge E0: a 2-deep tag pipeline records {valid=is_read, port}.
  - Edge E1: the SRAM samples the access.
  - Edge E2: in_mem_data is registered into the tagged port's out_x_rdata and out_x_rvalid pulses for one cycle.
  - Read latency is therefore 2 clocks from the accept edge.
  - The non-tagged port's rdata holds its last value.
  - Writes produce no rvalid.
- Ordering: accesses reach the SRAM in accept order.
  - A read accepted the cycle after a write to the same address returns the new data.
  - Read-return order per port equals accept order.
- Reset (in_reset_n=0, any time, including mid-transfer):
  - Immediately clears out_mem_writeenable, out_mem_addr, out_mem_data, out_a_rdata, out_b_rdata, out_a_rvalid, out_b_rvalid and the tag pipeline. Sets last_grant=B.
  - Acks are 0 while in reset.
  - Reads in flight at reset never produce rvalid after release.
- Idle: no requests gives no SRAM writes and no rvalid beyond those already in flight.

Test Plan:
1. After reset, B writes 0x5A to 0x0010, then A reads 0x0010 → out_a_ack 1 cycle; out_a_rvalid pulses exactly 2 clocks after accept edge; out_a_rdata=0x5A; out_b_rvalid stays 0.
2. A and B both hold read requests for 6 cycles, urgent=0 → acks alternate A,B,A,B,A,B starting with A; each rvalid returns on the correct port 2 clocks after its ack, with data from its own address.
3. Both request, in_b_urgent=1 for 3 cycles, then 0 → B acked 3 consecutive cycles, then A acked next, then alternation resumes.
4. A writes 0x33 to 0x0100, then next cycle reads 0x0100 (back-to-back) → two consecutive acks; out_mem_writeenable high only in the first issue cycle; out_a_rdata=0x33.
5. Two reads in flight, in_reset_n pulsed low for 1 cycle mid-flight → all outputs 0 during reset; no rvalid after release; next conflict granted to A.
6. No requests for 10 cycles after activity → out_mem_writeenable=0 throughout; out_mem_addr holds last value; no acks or rvalid.
